instr_issuer: RTL and testbench



---
 rtl/instr_pkg.sv | 48 ++++
 rtl/instr_fifo.sv | 56 +++++
 rtl/instr_issuer.sv | 120 ++++++++++++
 tb/tb_instr_issuer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Opcode constants, field positions and decode helpers for 16-bit compute-unit instructions.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package instr_pkg;

  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;

  localparam int OPC_LSB  = 12;
  localparam int TGT_LSB  = 8;
  localparam int SRC0_LSB = 4;
  localparam int SRC1_LSB = 0;

  function automatic logic [3:0] get_opc(input logic [INSTR_W-1:0] i);
    return i[OPC_LSB +: 4];
  endfunction

  function automatic logic [3:0] get_tgt(input logic [INSTR_W-1:0] i);
    return i[TGT_LSB +: 4];
  endfunction

  function automatic logic [3:0] get_src0(input logic [INSTR_W-1:0] i);
    return i[SRC0_LSB +: 4];
  endfunction

  function automatic logic [3:0] get_src1(input logic [INSTR_W-1:0] i);
    return i[SRC1_LSB +: 4];
  endfunction

  // Ops that write a register (LOAD included) and so can create a dependency.
  function automatic logic writes_reg(input logic [3:0] op);
    return (op >= OP_LOAD) && (op <= OP_XOR);
  endfunction

  // Ops that read source registers.
  function automatic logic reads_src(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of W-bit words, DEPTH entries (power of two), flush has priority.
// Latency: a word pushed at edge k is visible at dout and poppable from edge k+1.
// Backpressure: full/empty flags; push while full and pop while empty are ignored.
module instr_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  logic do_push;
  logic do_pop;

  // The extra MSB on each pointer separates full from empty when the indices match.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointer update; flush rewinds both pointers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_issuer.sv
// Assembles byte pairs (high first) into 16-bit instructions, buffers them, issues one per cycle.
// Latency: low byte accepted at edge k -> en=1 after edge k+1 (registered outputs, no bypass).
// Backpressure: byte_ready = !full in either phase; hold stalls issue. Optional macro: INSTR_ISSUER_HAZARD_EN.
module instr_issuer
  import instr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic                   hold,
  input  logic                   flush,
  output logic [INSTR_W-1:0]     instruction,
  output logic                   en,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       issued_count,
  output logic                   phase
);

  logic               full;
  logic               empty;
  logic [INSTR_W-1:0] head;
  logic [7:0]         hi_byte;
  logic               accept;
  logic               push;
  logic               pop;
  logic               stall;

  assign byte_ready = !full;
  assign accept     = byte_valid && byte_ready && !flush;
  assign push       = accept && phase;
  assign pop        = !empty && !hold && !stall && !flush;

  instr_fifo #(
    .W     (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (push),
    .din   ({hi_byte, byte_in}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Byte assembler: capture the high byte, then push it together with the low byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase   <= 1'b0;
      hi_byte <= '0;
    end else if (flush) begin
      phase   <= 1'b0;
    end else if (accept) begin
      if (!phase) hi_byte <= byte_in;
      phase <= !phase;
    end
  end

  // Issue stage: registered instruction/en, No-Op whenever nothing is issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en           <= 1'b0;
      instruction  <= '0;
      issued_count <= '0;
    end else if (flush) begin
      en           <= 1'b0;
      instruction  <= '0;
      issued_count <= '0;
    end else if (pop) begin
      en           <= 1'b1;
      instruction  <= head;
      issued_count <= issued_count + 1'b1;
    end else begin
      en           <= 1'b0;
      instruction  <= '0;
    end
  end

`ifdef INSTR_ISSUER_HAZARD_EN
  logic [3:0] last_tgt;
  logic       last_vld;
  logic [3:0] head_opc;
  logic       src_hit;

  assign head_opc = get_opc(head);

  // Read-after-write check of the head against the previously issued writer; NOT has no src1.
  always_comb begin
    src_hit = (get_src0(head) == last_tgt) ||
              ((head_opc != OP_NOT) && (get_src1(head) == last_tgt));
    stall   = !empty && !hold && last_vld && reads_src(head_opc) && src_hit;
  end

  // Track the last issued writer; a bubble consumes the dependency so it stalls only once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_tgt <= '0;
      last_vld <= 1'b0;
    end else if (flush) begin
      last_vld <= 1'b0;
    end else if (stall) begin
      last_vld <= 1'b0;
    end else if (pop) begin
      last_tgt <= get_tgt(head);
      last_vld <= writes_reg(head_opc);
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issuer.sv
// Directed self-checking bench for instr_issuer with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Hazard expectations follow INSTR_ISSUER_HAZARD_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_instr_issuer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        hold;
  logic        flush;
  logic [15:0] instruction;
  logic        en;
  logic [2:0]  fifo_count;
  logic [7:0]  issued_count;
  logic        phase;

  int n_checks = 0;
  int n_errors = 0;

  instr_issuer #(.DEPTH(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .hold         (hold),
    .flush        (flush),
    .instruction  (instruction),
    .en           (en),
    .fifo_count   (fifo_count),
    .issued_count (issued_count),
    .phase        (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    step();
    byte_valid = 1'b0;
  endtask

  logic [15:0] stream [10];
  logic [7:0]  sbytes [20];

  initial begin
    rstn = 1'b0; byte_in = '0; byte_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    step(); step();

    // Reset state
    check("rst_en", en, 0);
    check("rst_instr", instruction, 0);
    check("rst_count", fifo_count, 0);
    check("rst_issued", issued_count, 0);
    check("rst_phase", phase, 0);
    check("rst_ready", byte_ready, 1);
    rstn = 1'b1;
    step();

    // Single instruction 0x132A, issued one cycle after the push edge
    send_byte(8'h13);
    check("t1_phase1", phase, 1);
    send_byte(8'h2A);
    check("t1_pushed_cnt", fifo_count, 1);
    check("t1_no_bypass", en, 0);
    step();
    check("t1_en", en, 1);
    check("t1_instr", instruction, 16'h132A);
    check("t1_issued", issued_count, 1);
    step();
    check("t1_en_drop", en, 0);
    check("t1_instr_nop", instruction, 0);

    // Fill under hold, then full behaviour, then drain in order
    hold = 1'b1;
    for (int j = 0; j < 4; j++) begin
      send_byte(8'(8'hA0 + j));
      send_byte(8'(8'h01 + j));
    end
    check("t2_full_cnt", fifo_count, 4);
    check("t2_ready0", byte_ready, 0);
    check("t2_en_held", en, 0);
    send_byte(8'hFF);
    check("t3_phase_stays", phase, 0);
    check("t3_cnt_stays", fifo_count, 4);
    hold = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check("t2_drain_en", en, 1);
      check("t2_drain_instr", instruction, {8'(8'hA0 + j), 8'(8'h01 + j)});
      if (j == 0) check("t3_ready_after_pop", byte_ready, 1);
    end
    check("t2_drained", fifo_count, 0);
    check("t2_issued", issued_count, 5);
    step();
    check("t2_idle_en", en, 0);

    // Flush drops a partial instruction and a byte presented with flush
    send_byte(8'h11);
    check("t4_phase1", phase, 1);
    flush = 1'b1; byte_valid = 1'b1; byte_in = 8'h99;
    step();
    flush = 1'b0; byte_valid = 1'b0;
    check("t4_flush_phase", phase, 0);
    check("t4_flush_cnt", fifo_count, 0);
    check("t4_flush_issued", issued_count, 0);
    send_byte(8'h12);
    send_byte(8'h05);
    step();
    check("t4_en", en, 1);
    check("t4_instr", instruction, 16'h1205);
    step();

    // Ten-instruction stream with hold toggling every three cycles
    flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stream[i]       = {8'(8'hB0 + i), 8'(8'h40 + i)};
      sbytes[2*i]     = 8'(8'hB0 + i);
      sbytes[2*i + 1] = 8'(8'h40 + i);
    end
    begin
      int bi;
      int got;
      logic acc;
      bi = 0; got = 0;
      for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
        hold       = ((cyc / 3) % 2) == 1;
        byte_valid = (bi < 20);
        byte_in    = (bi < 20) ? sbytes[bi] : 8'h00;
        acc        = byte_valid && byte_ready;
        step();
        if (acc) bi++;
        if (en) begin
          if (got < 10) check("t5_stream", instruction, stream[got]);
          else check("t5_duplicate", 1, 0);
          got++;
        end
      end
      byte_valid = 1'b0; hold = 1'b0;
      check("t5_received", got, 10);
      step();
      check("t5_issued", issued_count, 10);
      check("t5_no_extra", en, 0);
    end

    // Asynchronous reset while an instruction is being issued
    send_byte(8'hC1);
    send_byte(8'h23);
    send_byte(8'h55);
    check("t6_en_before", en, 1);
    check("t6_phase_before", phase, 1);
    #2 rstn = 1'b0;
    #1;
    check("t6_async_en", en, 0);
    check("t6_async_instr", instruction, 0);
    check("t6_async_issued", issued_count, 0);
    check("t6_async_phase", phase, 0);
    check("t6_async_cnt", fifo_count, 0);
    step();
    rstn = 1'b1;
    step();

    // Dependency: LOAD r3 then ADD r3,r3,r2
    hold = 1'b1;
    send_byte(8'h13); send_byte(8'h05);
    send_byte(8'h23); send_byte(8'h32);
    hold = 1'b0;
    step();
    check("t7_first", instruction, 16'h1305);
`ifdef INSTR_ISSUER_HAZARD_EN
    step();
    check("t7_bubble_en", en, 0);
    check("t7_bubble_cnt", fifo_count, 1);
`endif
    step();
    check("t7_second_en", en, 1);
    check("t7_second", instruction, 16'h2332);
    step();

    // No dependency: LOAD r3 then ADD r4,r4,r2 issues back to back
    hold = 1'b1;
    send_byte(8'h13); send_byte(8'h05);
    send_byte(8'h24); send_byte(8'h42);
    hold = 1'b0;
    step();
    check("t8_first", instruction, 16'h1305);
    step();
    check("t8_b2b_en", en, 1);
    check("t8_second", instruction, 16'h2442);
    step();
    check("t8_idle", en, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
